pcie_ptile_tx_fc_arb: RTL and testbench

//  Arbitrates the single P-Tile TX streaming port among three TLP sources (posted, non-posted, completion).

---
 rtl/pcie_ptile_tx_fc_arb.sv | 137 +++++++++++++
 tb/tb_pcie_ptile_tx_fc_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_ptile_tx_fc_arb.sv
// TX port arbiter for P-Tile: round-robin among posted, non-posted and completion
// sources, gated by flow-control credits captured from the TDM credit-limit stream.
module pcie_ptile_tx_fc_arb #(
  parameter int HDR_CW  = 12,
  parameter int DATA_CW = 16,
  parameter int DW_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       tx_cdts_limit,
  input  logic [2:0]        tx_cdts_limit_tdm_idx,
  input  logic [2:0]        req_valid,
  input  logic [3*DW_W-1:0] req_dw,
  output logic [2:0]        gnt,
  output logic              busy,
  input  logic              tx_done,
  output logic [2:0]        fc_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [HDR_CW-1:0]  hdr_limit  [3];
  logic [HDR_CW-1:0]  hdr_cons   [3];
  logic [DATA_CW-1:0] data_limit [3];
  logic [DATA_CW-1:0] data_cons  [3];
  logic [2:0]         hdr_lv;
  logic [2:0]         data_lv;
  logic [1:0]         last_ptr;

  logic [HDR_CW-1:0]  hdr_avail  [3];
  logic [DATA_CW-1:0] data_avail [3];
  logic [DATA_CW-1:0] need       [3];
  logic [2:0]         credit_ok;
  logic [2:0]         eligible;

  logic [1:0]         ord0, ord1, ord2;
  logic [1:0]         pick;
  logic               pick_valid;
  logic [2:0]         gnt_next;
  logic               take;

  // One data credit covers four dwords; partial groups round up.
  function automatic logic [DATA_CW-1:0] data_need(input logic [DW_W-1:0] dw);
    logic [DW_W:0] sum;
    sum = {1'b0, dw} + (DW_W+1)'(3);
    return DATA_CW'(sum >> 2);
  endfunction

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      need[t]       = data_need(req_dw[t*DW_W +: DW_W]);
      hdr_avail[t]  = hdr_limit[t] - hdr_cons[t];
      data_avail[t] = data_limit[t] - data_cons[t];
      credit_ok[t]  = hdr_lv[t] & data_lv[t] & (hdr_avail[t] != '0) &
                      (data_avail[t] >= need[t]);
    end
    eligible = req_valid & credit_ok;
  end

  // Search order starts just after the most recently granted source.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (last_ptr)
      2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    pick_valid = 1'b1;
    pick       = ord0;
    if (eligible[ord0])      pick = ord0;
    else if (eligible[ord1]) pick = ord1;
    else if (eligible[ord2]) pick = ord2;
    else                     pick_valid = 1'b0;
  end

  always_comb begin
    state_next = state;
    gnt_next   = 3'b000;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = BUSY;
          gnt_next   = 3'b001 << pick;
          take       = 1'b1;
        end
      end
      BUSY: begin
        if (tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      last_ptr <= 2'd2;
      hdr_lv   <= 3'b000;
      data_lv  <= 3'b000;
      for (int t = 0; t < 3; t++) begin
        hdr_limit[t]  <= '0;
        hdr_cons[t]   <= '0;
        data_limit[t] <= '0;
        data_cons[t]  <= '0;
      end
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      if (take) last_ptr <= pick;
      for (int t = 0; t < 3; t++) begin
        if (take && (pick == 2'(t))) begin
          hdr_cons[t]  <= hdr_cons[t] + HDR_CW'(1);
          data_cons[t] <= data_cons[t] + need[t];
        end
        // Limit capture commits alongside consumption; the grant above used the old limit.
        if (tx_cdts_limit_tdm_idx == 3'(t)) begin
          hdr_limit[t] <= tx_cdts_limit[HDR_CW-1:0];
          hdr_lv[t]    <= 1'b1;
        end
        if (tx_cdts_limit_tdm_idx == 3'(t + 4)) begin
          data_limit[t] <= tx_cdts_limit[DATA_CW-1:0];
          data_lv[t]    <= 1'b1;
        end
      end
    end
  end

  assign busy     = (state == BUSY);
  assign fc_ready = hdr_lv & data_lv;

endmodule

// File: tb/tb_pcie_ptile_tx_fc_arb.sv
// Bench for pcie_ptile_tx_fc_arb: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a transaction-level credit model.
module tb_pcie_ptile_tx_fc_arb;
  localparam int DW_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       lim = '0;
  logic [2:0]        idx = 3'd3;
  logic [2:0]        rv  = '0;
  logic [3*DW_W-1:0] dw  = '0;
  logic              tx_done = 1'b0;
  logic [2:0]        gnt;
  logic              busy;
  logic [2:0]        fc_ready;

  always #5 clk = ~clk;

  pcie_ptile_tx_fc_arb #(.HDR_CW(12), .DATA_CW(16), .DW_W(DW_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .tx_cdts_limit         (lim),
    .tx_cdts_limit_tdm_idx (idx),
    .req_valid             (rv),
    .req_dw                (dw),
    .gnt                   (gnt),
    .busy                  (busy),
    .tx_done               (tx_done),
    .fc_ready              (fc_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: cumulative limits, consumed totals, port ownership.
  int       m_hlim[3], m_dlim[3], m_hcons[3], m_dcons[3];
  bit       m_hv[3], m_dv[3];
  bit       m_busy;
  int       m_last;
  logic [2:0] e_gnt;
  logic       e_busy;
  logic [2:0] e_fc;

  typedef struct {
    logic        r;
    logic [2:0]  ix;
    logic [15:0] lm;
    logic [2:0]  rq;
    logic [10:0] d;
    logic        dn;
    logic [2:0]  eg;
    logic        eb;
    logic [2:0]  ef;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic [2:0] ix, input logic [15:0] lm,
                              input logic [2:0] rq, input logic [10:0] d, input logic dn,
                              input logic [2:0] eg, input logic eb, input logic [2:0] ef);
    vec_t v;
    v.r = r; v.ix = ix; v.lm = lm; v.rq = rq; v.d = d; v.dn = dn;
    v.eg = eg; v.eb = eb; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  need[3];
    bit  ok[3];
    int  ah, ad, t;
    bit  found;
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        m_hlim[s] = 0; m_dlim[s] = 0; m_hcons[s] = 0; m_dcons[s] = 0;
        m_hv[s] = 0; m_dv[s] = 0;
      end
      m_busy = 0;
      m_last = 2;
      e_gnt  = 3'b000;
    end else begin
      for (int s = 0; s < 3; s++) begin
        need[s] = (int'(dw[s*DW_W +: DW_W]) + 3) / 4;
        ah = (m_hlim[s] - m_hcons[s] + 4096) % 4096;
        ad = (m_dlim[s] - m_dcons[s] + 65536) % 65536;
        ok[s] = rv[s] && m_hv[s] && m_dv[s] && (ah >= 1) && (ad >= need[s]);
      end
      e_gnt = 3'b000;
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          t = (m_last + k) % 3;
          if (!found && ok[t]) begin
            found      = 1;
            e_gnt      = 3'(1 << t);
            m_hcons[t] = (m_hcons[t] + 1) % 4096;
            m_dcons[t] = (m_dcons[t] + need[t]) % 65536;
            m_last     = t;
            m_busy     = 1;
          end
        end
      end else if (tx_done) begin
        m_busy = 0;
      end
      if (idx < 3) begin
        m_hlim[idx] = int'(lim) % 4096;
        m_hv[idx]   = 1;
      end else if (idx >= 4 && idx <= 6) begin
        m_dlim[idx-4] = int'(lim);
        m_dv[idx-4]   = 1;
      end
    end
    e_busy = m_busy;
    for (int s = 0; s < 3; s++) e_fc[s] = m_hv[s] && m_dv[s];
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "_gnt"}, int'(gnt), int'(e_gnt));
    chk({tag, "_busy"}, int'(busy), int'(e_busy));
    chk({tag, "_fc_ready"}, int'(fc_ready), int'(e_fc));
  endtask

  task automatic set_dw_all(input logic [10:0] d);
    for (int s = 0; s < 3; s++) dw[s*DW_W +: DW_W] = d;
  endtask

  initial begin
    int cnt, n, np, pp, cp, guard;
    int ch[3], cd[3];
    bit pend[3];

    // Directed table: reset, credit gating, RR order, reset while busy.
    tv.push_back(mk(1, 3, 0,    3'b000, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 3, 0,    3'b111, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 3, 0,    3'b111, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 3, 0,    3'b111, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 0, 4,    3'b000, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 4, 8,    3'b000, 0,  0, 3'b000, 0, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b001, 32, 0, 3'b001, 1, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b000, 0,  1, 3'b000, 0, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b001, 1,  0, 3'b000, 0, 3'b001));
    tv.push_back(mk(0, 4, 9,    3'b001, 1,  0, 3'b000, 0, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b001, 1,  0, 3'b001, 1, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b000, 0,  1, 3'b000, 0, 3'b001));
    tv.push_back(mk(1, 3, 0,    3'b000, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 0, 100,  3'b000, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 1, 100,  3'b000, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 2, 100,  3'b000, 0,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 4, 1000, 3'b000, 0,  0, 3'b000, 0, 3'b001));
    tv.push_back(mk(0, 5, 1000, 3'b000, 0,  0, 3'b000, 0, 3'b011));
    tv.push_back(mk(0, 6, 1000, 3'b000, 0,  0, 3'b000, 0, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b001, 1, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  1, 3'b000, 0, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b010, 1, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  1, 3'b000, 0, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b100, 1, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  1, 3'b000, 0, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b001, 1, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  1, 3'b000, 0, 3'b111));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b010, 1, 3'b111));
    tv.push_back(mk(1, 3, 0,    3'b111, 4,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 0, 5,    3'b111, 4,  0, 3'b000, 0, 3'b000));
    tv.push_back(mk(0, 4, 8,    3'b111, 4,  0, 3'b000, 0, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b111, 4,  0, 3'b001, 1, 3'b001));
    tv.push_back(mk(0, 3, 0,    3'b000, 0,  1, 3'b000, 0, 3'b001));

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].r; idx = tv[i].ix; lim = tv[i].lm; rv = tv[i].rq; tx_done = tv[i].dn;
      set_dw_all(tv[i].d);
      step("tbl");
      chk($sformatf("row%0d_gnt", i), int'(gnt), int'(tv[i].eg));
      chk($sformatf("row%0d_busy", i), int'(busy), int'(tv[i].eb));
      chk($sformatf("row%0d_fc_ready", i), int'(fc_ready), int'(tv[i].ef));
    end

    // Header counter wrap: drive PH consumed up to 0xFFE, then limit 0xFFF -> 0x001.
    rst = 1; idx = 3; rv = 0; tx_done = 0; set_dw_all(0);
    step("wrap");
    rst = 0; idx = 4; lim = 0;
    step("wrap");
    cnt = 0; guard = 0; rv = 3'b001; tx_done = 1;
    while (cnt < 4094 && guard < 10000) begin
      idx = 0;
      lim = 16'((cnt + 1000 > 4094) ? 4094 : cnt + 1000);
      step("wrap");
      if (e_gnt[0]) cnt++;
      guard++;
    end
    chk("wrap_reach", cnt, 4094);
    rv = 0; idx = 3;
    step("wrap");
    idx = 0; lim = 16'h0FFF;
    step("wrap");
    idx = 0; lim = 16'h0001;
    step("wrap");
    idx = 3; rv = 3'b001;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step("wrap");
      if (gnt[0]) n++;
    end
    chk("wrap_grants", n, 3);

    // NP starved of header credits while P and CPL keep flowing.
    rst = 1; rv = 0; idx = 3; tx_done = 0;
    step("starve");
    rst = 0;
    idx = 0; lim = 100;  step("starve");
    idx = 1; lim = 0;    step("starve");
    idx = 2; lim = 100;  step("starve");
    idx = 4; lim = 1000; step("starve");
    idx = 5; lim = 1000; step("starve");
    idx = 6; lim = 1000; step("starve");
    idx = 3; rv = 3'b111; tx_done = 1;
    np = 0; pp = 0; cp = 0;
    for (int i = 0; i < 12; i++) begin
      step("starve");
      if (gnt[0]) pp++;
      if (gnt[1]) np++;
      if (gnt[2]) cp++;
    end
    chk("starve_p", pp, 3);
    chk("starve_cpl", cp, 3);
    chk("starve_np", np, 0);
    guard = 0;
    do begin
      step("starve");
      guard++;
    end while (gnt != 3'b001 && guard < 10);
    chk("starve_p_seen", int'(gnt), 1);
    idx = 1; lim = 1;
    step("starve");
    idx = 3;
    step("starve");
    chk("np_after_update", int'(gnt), 2);

    // Randomized traffic against the model.
    rst = 1; rv = 0; tx_done = 0; idx = 3;
    step("rnd");
    rst = 0;
    for (int s = 0; s < 3; s++) begin ch[s] = 0; cd[s] = 0; pend[s] = 0; end
    for (int c = 0; c < 3000; c++) begin
      idx = 3'($urandom % 8);
      if (idx < 3) begin
        ch[idx] += $urandom % 4;
        lim = {4'($urandom), 12'(ch[idx])};
      end else if (idx >= 4 && idx <= 6) begin
        cd[idx-4] += $urandom % 81;
        lim = 16'(cd[idx-4]);
      end else begin
        lim = 16'($urandom);
      end
      for (int s = 0; s < 3; s++) begin
        if (!pend[s] && ($urandom % 3 == 0)) begin
          pend[s] = 1;
          dw[s*DW_W +: DW_W] = ($urandom % 4 == 0) ? 11'($urandom % 1025) : 11'($urandom % 65);
        end else if (pend[s] && ($urandom % 60 == 0)) begin
          pend[s] = 0;
        end
        rv[s] = pend[s];
      end
      tx_done = m_busy ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      rst = ($urandom % 700 == 0);
      step("rnd");
      if (rst) begin
        for (int s = 0; s < 3; s++) begin ch[s] = 0; cd[s] = 0; pend[s] = 0; end
        rst = 0;
      end
      for (int s = 0; s < 3; s++) if (e_gnt[s]) pend[s] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
